nibble_serial_add_ctrl: RTL
===========================

Name: nibble_serial_add_ctrl

Overview:
- Multi-cycle sequencer that computes a WIDTH-bit sum by reusing one 4-bit ripple-carry slice, built from four fulladder cells, over WIDTH/4 beats.
- Latches operands, feeds one nibble per cycle into the slice, and registers the slice carry-out into the next beat's carry-in.
- Assembles the result and presents it on a valid/ready output handshake.
- Sits between a requester (ALU issue logic) and the area-cheap adder slice; trades latency for gate count.

Parameters:
WIDTH  32  operand/result width in bits; must be a multiple of 4 and at least 4
BEATS  WIDTH/4  derived (localparam) number of slice passes; not overridable

Ports:
clk          in   1       clock; all state updates on rising edge
rst          in   1       asynchronous, active-high reset
start_valid  in   1       requester presents an operation
start_ready  out  1       controller can accept an operation (high only in IDLE)
a            in   WIDTH   operand A, sampled on start handshake
b            in   WIDTH   operand B, sampled on start handshake
cin          in   1       carry-in, sampled on start handshake
done_valid   out  1       result valid (high only in DONE)
done_ready   in   1       consumer accepts result
sum          out  WIDTH   registered result
cout         out  1       registered final carry-out
busy         out  1       high in RUN or DONE
beat_idx     out  $clog2(BEATS) (min 1)  current nibble index in RUN; 0 otherwise

Behaviour:
- Reset (async assert on rst=1, takes effect immediately):
  - state=IDLE; operand regs, sum, cout, carry reg and beat_idx cleared to 0.
  - Outputs: start_ready=1, done_valid=0, busy=0.
- Reset mid-operation aborts the operation with no output; the first cycle after deassert is IDLE.
- States: IDLE, RUN, DONE (binary-encoded, one registered state vector).
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready at edge T: latch a, b; carry reg<=cin; beat_idx<=0; state<=RUN.
- RUN, beat k = beat_idx:
  - The slice sees a[4k+3:4k], b[4k+3:4k] and the carry reg.
  - Each edge: sum[4k+3:4k]<=slice sum; carry reg<=slice cout; beat_idx<=k+1.
  - At k=BEATS-1: cout<=slice cout; beat_idx<=0; state<=DONE.
  - start_ready=0. start_valid is ignored; a, b and cin may change freely.
- DONE:
  - done_valid=1; sum and cout are stable.
  - On done_ready: state<=IDLE.
  - done_valid held indefinitely while done_ready=0.
  - No operation is accepted in the cycle done completes; the next accept is earliest in the following IDLE cycle.
- Latency: accept at edge T gives done_valid high after edge T+BEATS (8 for WIDTH=32).
- Throughput: one operation per BEATS+2 cycles with done_ready tied high.
- Arithmetic:
  - Unsigned modulo 2^WIDTH. cout = bit WIDTH of a+b+cin.
  - Nibble carry chain is exact; all-ones + 1 wraps to 0 with cout=1.
- WIDTH=4: BEATS=1; RUN lasts one cycle.
- sum holds the previous result until overwritten nibble-by-nibble in the next RUN; it is only meaningful while done_valid=1.

Optional Feature:
- Macro: NIBBLE_ADD_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), registered at the final beat.
  - ovf = carry into MSB XOR carry out of MSB (two's-complement overflow). This needs an internal tap of the slice's bit-2 carry.
  - ovf reset to 0; valid with done_valid.
- Undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 mid-RUN at beat 3 -> same cycle busy=0, start_ready=1, done_valid=0, sum=0, cout=0; after deassert, a new operation completes correctly.
- Basic add: a=0x0000_0005, b=0x0000_0003, cin=0, accept at T -> done_valid rises after edge T+8; sum=0x0000_0008, cout=0.
- Full carry ripple: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1. Carry propagates through all 8 beats; beat_idx counts 0..7.
- Backpressure: a=0x1234_5678, b=0x1111_1111, done_ready=0 for 5 cycles -> done_valid stays 1; sum=0x2345_6789 stable; start_ready=0 throughout; start_valid pulses ignored.
- Back-to-back: start_valid and done_ready held 1 with two queued operations -> second accept occurs exactly BEATS+2 cycles after the first; results are in order.
- NIBBLE_ADD_OVF_EN: a=0x7FFF_FFFF, b=0x0000_0001 -> sum=0x8000_0000, cout=0, ovf=1. a=0xFFFF_FFFF, b=0x0000_0001 -> ovf=0, cout=1.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: WIDTH-bit add over WIDTH/4 passes of a 4-bit fulladder slice; NIBBLE_ADD_OVF_EN adds the ovf output
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 32,
  localparam int BEATS = WIDTH / 4,
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic [BW-1:0]    beat_idx
`ifdef NIBBLE_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_r, b_r;
  logic [3:0] na, nb, s;
  logic [4:0] c;
  logic carry_r, last;
  assign na = a_r[{beat_idx, 2'b00} +: 4];
  assign nb = b_r[{beat_idx, 2'b00} +: 4];
  assign c[0] = carry_r;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    fulladder u_fa (.a(na[i]), .b(nb[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end
  assign last = beat_idx == BW'(BEATS - 1);
  assign start_ready = state == IDLE;
  assign done_valid = state == DONE;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start_valid ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) :
                              (done_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      carry_r <= 1'b0;
      beat_idx <= '0;
      sum <= '0;
      cout <= 1'b0;
`ifdef NIBBLE_ADD_OVF_EN
      ovf <= 1'b0;
`endif
    end else if (state == IDLE && start_valid) begin
      a_r <= a;
      b_r <= b;
      carry_r <= cin;
      beat_idx <= '0;
    end else if (state == RUN) begin
      sum[{beat_idx, 2'b00} +: 4] <= s;
      carry_r <= c[4];
      beat_idx <= last ? '0 : beat_idx + 1'b1;
      if (last) cout <= c[4];
`ifdef NIBBLE_ADD_OVF_EN
      // two's-complement overflow: carry into the MSB differs from carry out of it
      if (last) ovf <= c[3] ^ c[4];
`endif
    end
  end
endmodule
